lfsr_decryptor_core: RTL and testbench
======================================

# lfsr_decryptor_core

- Parametrised LFSR stream decryptor. It reads ciphertext from a synchronous byte memory and recovers the LFSR seed from a known preamble character.
- It either uses supplied taps (fixed mode) or searches a tap table until the preamble decrypts cleanly (search mode).
- It writes plaintext back to a destination region of the same memory.
- It is the DUT that the decryptor BFM drives via init/raddr/waddr/wr_en/data_in/data_out/done; it adds width generalisation, tap search and a fail flag.

## Interface
- DATA_W, 8: memory data width.
- ADDR_W, 8: memory address width.
- LFSR_W, 6: LFSR width; must satisfy 2 ≤ LFSR_W ≤ DATA_W.
- SRC_BASE, 0: ciphertext base address.
- DST_BASE, 64: plaintext base address.
- PRE_LEN, 7: preamble length in bytes; must be ≥ 2.
- PRE_CHAR, 8'h5F: preamble character.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- init  in  1  start pulse; sampled only in IDLE/DONE.
- mode  in  1  0 = fixed taps, 1 = tap search; sampled with init.
- taps_in  in  LFSR_W  tap mask used in fixed mode; sampled with init.
- msg_len  in  ADDR_W  total bytes including preamble; sampled with init.
- raddr  out  ADDR_W  memory read address.
- data_in  in  DATA_W  memory read data, valid the cycle after raddr.
- waddr  out  ADDR_W  memory write address.
- data_out  out  DATA_W  plaintext write data.
- wr_en  out  1  one-cycle write strobe.
- done  out  1  operation finished; held until the next accepted init.
- fail  out  1  search exhausted with no matching taps; valid while done=1.
- found_taps  out  LFSR_W  taps used (fixed or locked); valid while done=1.

## Operation
- LFSR step: next = {s[LFSR_W-2:0], ^(s & taps)}.
- Key byte k_i: zero-extended state, with k_0 = seed and k_{i+1} = step(k_i).
- Plaintext: p_i = c_i ^ k_i.
- Seed derivation: seed = (c_0 ^ PRE_CHAR)[LFSR_W-1:0].
- Addresses: SRC_BASE+i and DST_BASE+i, both wrapping modulo 2^ADDR_W.
- Every byte access is two cycles: RD (raddr driven) then USE (data_in consumed).
- State sequence: IDLE → SEED → (search mode: CHECK ⇄ NEXT_TAP) → DECRYPT → DONE.
  - SEED: read c_0 and derive seed; seed is computed once per run.
  - CHECK: using candidate TAP_TABLE[t], bytes i = 1..PRE_LEN-1 must decrypt to PRE_CHAR.
    - On first mismatch go to NEXT_TAP: t++, reload the state with seed, restart at i = 1.
    - When all preamble bytes match, lock the taps.
  - NEXT_TAP: if t = NUM_TAPS-1 already, go to DONE with fail=1 and perform no writes.
  - Fixed mode skips CHECK and never sets fail; a corrupt preamble is still written as decrypted.
  - DECRYPT: reload the state with seed; for i = 0..msg_len-1 read c_i and write p_i to DST_BASE+i.
- msg_len = 0: go SEED-less directly to DONE; no writes; fail=0.
- Search mode with msg_len < PRE_LEN: check only bytes 1..msg_len-1.
- init while busy is ignored; init in DONE clears done and fail and starts a new run.
- Reset (rst_n = 0 at an edge, including mid-operation) results in:
  - state IDLE;
  - raddr, waddr, data_out, found_taps = 0;
  - wr_en, done, fail = 0;
  - no further writes.

## Timing
- All outputs are registered.
- Cycle 0 is the edge where init is sampled.
- Seed read: RD in cycle 1, USE in cycle 2.
- Fixed mode, byte i:
  - RD in cycle 3+2i, USE in cycle 4+2i;
  - wr_en, waddr, data_out high in cycle 5+2i.
- Last write is in cycle 3+2N and done rises in cycle 4+2N (N = msg_len).
- Search mode: each checked preamble byte costs 2 cycles; NEXT_TAP costs 1 cycle.
- Decryption starts on the cycle after lock with the same 2-cycle-per-byte cadence.
- done rises one cycle after the final wr_en, or one cycle after the last NEXT_TAP on fail.
- wr_en is never high on consecutive cycles.

## Structure
- Package decryptor_pkg holds:
  - the state enum;
  - NUM_TAPS = 6;
  - TAP_TABLE for LFSR_W = 6: 6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39;
  - the PRE_CHAR default.
- Sub-module decryptor_lfsr holds the LFSR register with load (seed), step and taps inputs, exposing state; the core holds the FSM, counters and address generation.

## Test plan
- Fixed mode, taps 6'h21, seed 6'h01, N = 10, preamble "_______" plus "ABC":
  - c_0 = 8'h5E, k_1 = 6'h03;
  - DST_BASE..+9 must hold "_______ABC";
  - done in cycle 24; fail = 0.
- Search mode, message encrypted with TAP_TABLE[3] = 6'h33, N = 12:
  - found_taps = 6'h33, fail = 0;
  - exactly 12 writes with correct plaintext.
- Search mode with a preamble byte 3 corrupted for every tap: done = 1, fail = 1, zero wr_en pulses.
- msg_len = 0 in both modes: done in cycle 1, no writes, fail = 0.
- rst_n low for one edge during DECRYPT at i = 4:
  - next cycle all outputs are at reset values and no further writes occur;
  - a new init then completes normally.
- Second init pulse at cycle 6 of a run is ignored: the write sequence and done cycle are identical to a single-init run.

Source files
------------

// File: rtl/decryptor_pkg.sv
// Shared types and constants for the LFSR stream decryptor: FSM states,
// the candidate tap table used in search mode and the default preamble.
package decryptor_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEED_RD,
        S_SEED_USE,
        S_CHK_RD,
        S_CHK_USE,
        S_NEXT_TAP,
        S_DEC_RD,
        S_DEC_USE,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam int NUM_TAPS = 6;
    localparam int TAP_IDX_W = 3;
    localparam logic [7:0] PRE_CHAR_DEFAULT = 8'h5F;

    // Candidate tap masks for a 6-bit LFSR, tried in ascending index order.
    function automatic logic [5:0] tap_table(input logic [TAP_IDX_W-1:0] idx);
        logic [5:0] t;
        case (idx)
            3'd0:    t = 6'h21;
            3'd1:    t = 6'h2D;
            3'd2:    t = 6'h30;
            3'd3:    t = 6'h33;
            3'd4:    t = 6'h36;
            3'd5:    t = 6'h39;
            default: t = 6'h21;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lfsr_decryptor_core_if.sv
// Byte-memory port between the decryptor (master) and a synchronous RAM (slave).
interface lfsr_decryptor_core_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    // Read: raddr is presented one cycle, data_in carries mem[raddr] the next.
    // Write: wr_en is a single-cycle strobe qualifying waddr/data_out; no backpressure.
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] data_out;
    logic              wr_en;

    modport master (
        output raddr,
        output waddr,
        output data_out,
        output wr_en,
        input  data_in
    );

    modport slave (
        input  raddr,
        input  waddr,
        input  data_out,
        input  wr_en,
        output data_in
    );

endinterface

// File: rtl/decryptor_lfsr.sv
// Fibonacci-style LFSR keystream register: shifts left, feedback is the
// parity of the tapped bits. load has priority over step.
module decryptor_lfsr #(
    parameter int LFSR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] load_val,
    input  logic [LFSR_W-1:0] taps,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] s_q;
    logic [LFSR_W-1:0] s_d;

    always_comb begin
        s_d = s_q;
        if (load) begin
            s_d = load_val;
        end else if (step) begin
            s_d = {s_q[LFSR_W-2:0], ^(s_q & taps)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    assign state = s_q;

endmodule

// File: rtl/lfsr_decryptor_core.sv
// LFSR stream decryptor: derives the seed from a known preamble byte, optionally
// searches the tap table until the preamble decrypts, then writes plaintext back.
module lfsr_decryptor_core
    import decryptor_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                LFSR_W   = 6,
    parameter int                SRC_BASE = 0,
    parameter int                DST_BASE = 64,
    parameter int                PRE_LEN  = 7,
    parameter logic [DATA_W-1:0] PRE_CHAR = DATA_W'(PRE_CHAR_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init,
    input  logic                 mode,
    input  logic [LFSR_W-1:0]    taps_in,
    input  logic [ADDR_W-1:0]    msg_len,
    lfsr_decryptor_core_if.master mem,
    output logic                 done,
    output logic                 fail,
    output logic [LFSR_W-1:0]    found_taps,
    output state_t               dbg_state
);

    localparam logic [ADDR_W-1:0]    SRC_A     = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0]    DST_A     = ADDR_W'(DST_BASE);
    localparam logic [ADDR_W-1:0]    PRE_LEN_A = ADDR_W'(PRE_LEN);
    localparam logic [ADDR_W-1:0]    ONE_A     = ADDR_W'(1);
    localparam logic [TAP_IDX_W-1:0] LAST_TAP  = TAP_IDX_W'(NUM_TAPS - 1);

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [ADDR_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic [TAP_IDX_W-1:0] tap_idx_q, tap_idx_d;
    logic [LFSR_W-1:0]    taps_q, taps_d;
    logic [LFSR_W-1:0]    seed_q, seed_d;
    logic [ADDR_W-1:0]    raddr_q, raddr_d;
    logic [ADDR_W-1:0]    waddr_q, waddr_d;
    logic [DATA_W-1:0]    data_out_q, data_out_d;
    logic                 wr_en_q, wr_en_d;
    logic                 done_q, done_d;
    logic                 fail_q, fail_d;

    logic                 lfsr_load;
    logic                 lfsr_step;
    logic [LFSR_W-1:0]    lfsr_load_val;
    logic [LFSR_W-1:0]    lfsr_state;

    logic [DATA_W-1:0]    plain;
    logic [ADDR_W-1:0]    chk_len;
    logic [ADDR_W-1:0]    chk_last;
    logic [ADDR_W-1:0]    dec_last;
    logic [ADDR_W-1:0]    idx_inc;
    logic [TAP_IDX_W-1:0] tap_idx_nxt;

    decryptor_lfsr #(
        .LFSR_W (LFSR_W)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsr_load),
        .step     (lfsr_step),
        .load_val (lfsr_load_val),
        .taps     (taps_q),
        .state    (lfsr_state)
    );

    // Short messages only have bytes 1..msg_len-1 of the preamble to verify.
    assign plain       = mem.data_in ^ DATA_W'(lfsr_state);
    assign chk_len     = (len_q < PRE_LEN_A) ? len_q : PRE_LEN_A;
    assign chk_last    = chk_len - ONE_A;
    assign dec_last    = len_q - ONE_A;
    assign idx_inc     = idx_q + ONE_A;
    assign tap_idx_nxt = tap_idx_q + TAP_IDX_W'(1);

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        len_d         = len_q;
        idx_d         = idx_q;
        tap_idx_d     = tap_idx_q;
        taps_d        = taps_q;
        seed_d        = seed_q;
        raddr_d       = raddr_q;
        waddr_d       = waddr_q;
        data_out_d    = data_out_q;
        wr_en_d       = 1'b0;
        done_d        = done_q;
        fail_d        = fail_q;
        lfsr_load     = 1'b0;
        lfsr_step     = 1'b0;
        lfsr_load_val = seed_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (init) begin
                    mode_d    = mode;
                    len_d     = msg_len;
                    tap_idx_d = '0;
                    taps_d    = mode ? LFSR_W'(tap_table('0)) : taps_in;
                    fail_d    = 1'b0;
                    if (msg_len == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SEED_RD;
                        done_d  = 1'b0;
                        raddr_d = SRC_A;
                    end
                end
            end

            S_SEED_RD: state_d = S_SEED_USE;

            S_SEED_USE: begin
                seed_d        = LFSR_W'(mem.data_in ^ PRE_CHAR);
                lfsr_load     = 1'b1;
                lfsr_load_val = seed_d;
                if (mode_q && (len_q > ONE_A)) begin
                    idx_d   = ONE_A;
                    raddr_d = SRC_A + ONE_A;
                    state_d = S_CHK_RD;
                end else begin
                    idx_d   = '0;
                    raddr_d = SRC_A;
                    state_d = S_DEC_RD;
                end
            end

            // Key advances during the read cycle so it holds k_i when byte i arrives.
            S_CHK_RD: begin
                lfsr_step = 1'b1;
                state_d   = S_CHK_USE;
            end

            S_CHK_USE: begin
                if (plain != PRE_CHAR) begin
                    state_d = S_NEXT_TAP;
                end else if (idx_q == chk_last) begin
                    lfsr_load = 1'b1;
                    idx_d     = '0;
                    raddr_d   = SRC_A;
                    state_d   = S_DEC_RD;
                end else begin
                    idx_d   = idx_inc;
                    raddr_d = SRC_A + idx_inc;
                    state_d = S_CHK_RD;
                end
            end

            S_NEXT_TAP: begin
                if (tap_idx_q == LAST_TAP) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                end else begin
                    tap_idx_d = tap_idx_nxt;
                    taps_d    = LFSR_W'(tap_table(tap_idx_nxt));
                    lfsr_load = 1'b1;
                    idx_d     = ONE_A;
                    raddr_d   = SRC_A + ONE_A;
                    state_d   = S_CHK_RD;
                end
            end

            S_DEC_RD: state_d = S_DEC_USE;

            S_DEC_USE: begin
                wr_en_d    = 1'b1;
                waddr_d    = DST_A + idx_q;
                data_out_d = plain;
                lfsr_step  = 1'b1;
                if (idx_q == dec_last) begin
                    state_d = S_FLUSH;
                end else begin
                    idx_d   = idx_inc;
                    raddr_d = SRC_A + idx_inc;
                    state_d = S_DEC_RD;
                end
            end

            // Lets the final write strobe retire before done is raised.
            S_FLUSH: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            len_q      <= '0;
            idx_q      <= '0;
            tap_idx_q  <= '0;
            taps_q     <= '0;
            seed_q     <= '0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            data_out_q <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            tap_idx_q  <= tap_idx_d;
            taps_q     <= taps_d;
            seed_q     <= seed_d;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            data_out_q <= data_out_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
        end
    end

    assign mem.raddr    = raddr_q;
    assign mem.waddr    = waddr_q;
    assign mem.data_out = data_out_q;
    assign mem.wr_en    = wr_en_q;
    assign done         = done_q;
    assign fail         = fail_q;
    assign found_taps   = taps_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_lfsr_decryptor_core.sv
// Directed bench for lfsr_decryptor_core: expected writes are queued per run
// and a negedge monitor pops and compares every wr_en strobe.
module tb_lfsr_decryptor_core;
    import decryptor_pkg::*;

    localparam int DST = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init = 1'b0;
    logic       mode = 1'b0;
    logic [5:0] taps_in = '0;
    logic [7:0] msg_len = '0;
    logic       done;
    logic       fail;
    logic [5:0] found_taps;
    state_t     dbg_state;

    lfsr_decryptor_core_if #(.DATA_W(8), .ADDR_W(8)) mem_if ();

    lfsr_decryptor_core #(
        .DATA_W(8), .ADDR_W(8), .LFSR_W(6), .SRC_BASE(0), .DST_BASE(DST),
        .PRE_LEN(7), .PRE_CHAR(8'h5F)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .mode       (mode),
        .taps_in    (taps_in),
        .msg_len    (msg_len),
        .mem        (mem_if),
        .done       (done),
        .fail       (fail),
        .found_taps (found_taps),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / memory model ----------------
    always #5 clk = ~clk;

    logic [7:0] src_img [256];
    logic [7:0] dst_mem [256];
    logic       clr_dst = 1'b0;
    int         cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_if.data_in <= src_img[mem_if.raddr];
        if (clr_dst) begin
            for (int i = 0; i < 256; i++) dst_mem[i] <= 8'h00;
        end else if (mem_if.wr_en) begin
            dst_mem[mem_if.waddr] <= mem_if.data_out;
        end
    end

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    int          init_cyc = 0;
    logic [7:0]  pt [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    initial begin
        logic        prev_wr;
        logic [15:0] exp;
        prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_if.wr_en === 1'b1) begin
                wr_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                             mem_if.waddr, mem_if.data_out);
                end else begin
                    exp = exp_q.pop_front();
                    if ({mem_if.waddr, mem_if.data_out} !== exp) begin
                        errors++;
                        $display("FAIL write_data: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                                 mem_if.waddr, mem_if.data_out, exp[15:8], exp[7:0]);
                    end
                end
                checks++;
                if (prev_wr) begin
                    errors++;
                    $display("FAIL wr_back_to_back: got wr_en on consecutive cycles, expected a gap");
                end
            end
            prev_wr = (mem_if.wr_en === 1'b1);
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [5:0] model_step(input logic [5:0] s, input logic [5:0] t);
        return {s[4:0], ^(s & t)};
    endfunction

    task automatic set_pt_fixed();
        for (int i = 0; i < 7; i++) pt[i] = 8'h5F;
        pt[7] = 8'h41; pt[8] = 8'h42; pt[9] = 8'h43;
    endtask

    task automatic set_pt_search();
        for (int i = 0; i < 7; i++) pt[i] = 8'h5F;
        pt[7] = 8'h48; pt[8] = 8'h45; pt[9] = 8'h4C; pt[10] = 8'h4C; pt[11] = 8'h4F;
    endtask

    // Hand-computed ciphertext for "_______ABC", taps 6'h21, seed 6'h01.
    task automatic load_src_fixed();
        src_img[0] = 8'h5E; src_img[1] = 8'h5C; src_img[2] = 8'h58; src_img[3] = 8'h50;
        src_img[4] = 8'h40; src_img[5] = 8'h60; src_img[6] = 8'h61; src_img[7] = 8'h7C;
        src_img[8] = 8'h78; src_img[9] = 8'h76;
    endtask

    task automatic encrypt(input logic [5:0] seed, input logic [5:0] t, input int n);
        logic [5:0] k;
        k = seed;
        for (int i = 0; i < n; i++) begin
            src_img[i] = pt[i] ^ {2'b00, k};
            k = model_step(k, t);
        end
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({8'(DST + i), pt[i]});
    endtask

    task automatic clear_dst();
        @(negedge clk); clr_dst = 1'b1;
        @(negedge clk); clr_dst = 1'b0;
        wr_count = 0;
    endtask

    task automatic start_run(input logic m, input logic [5:0] tp, input logic [7:0] len);
        @(negedge clk);
        init = 1'b1; mode = m; taps_in = tp; msg_len = len;
        @(posedge clk); #1;
        init_cyc = cyc;
        init = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc = cyc - init_cyc + 1;
                break;
            end
        end
        if (dc < 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done within 400 cycles, expected done");
        end
    endtask

    task automatic check_dst(input string tag, input int n);
        for (int i = 0; i < n; i++)
            check($sformatf("%s_dst[%0d]", tag, i), 32'(dst_mem[DST + i]), 32'(pt[i]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_raddr"}, 32'(mem_if.raddr), 0);
        check({tag, "_waddr"}, 32'(mem_if.waddr), 0);
        check({tag, "_data_out"}, 32'(mem_if.data_out), 0);
        check({tag, "_wr_en"}, 32'(mem_if.wr_en), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_fail"}, 32'(fail), 0);
        check({tag, "_found_taps"}, 32'(found_taps), 0);
        check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int dc;
        for (int i = 0; i < 256; i++) src_img[i] = 8'h00;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        clear_dst();

        // Fixed mode, taps 6'h21
        set_pt_fixed(); load_src_fixed(); push_exp(10);
        start_run(1'b0, 6'h21, 8'd10);
        wait_done(dc);
        check("fixed_done_cycle", 32'(dc), 24);
        check("fixed_fail", 32'(fail), 0);
        check("fixed_found_taps", 32'(found_taps), 32'h21);
        check("fixed_wr_count", 32'(wr_count), 10);
        check("fixed_queue_left", 32'(exp_q.size()), 0);
        check_dst("fixed", 10);

        // Second init at cycle 6 must be ignored
        clear_dst(); push_exp(10);
        start_run(1'b0, 6'h21, 8'd10);
        repeat (6) @(negedge clk);
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        wait_done(dc);
        check("reinit_done_cycle", 32'(dc), 24);
        check("reinit_wr_count", 32'(wr_count), 10);
        check("reinit_queue_left", 32'(exp_q.size()), 0);

        // Search mode, message encrypted with taps 6'h33, seed 6'h2A
        set_pt_search(); encrypt(6'h2A, 6'h33, 12); clear_dst(); push_exp(12);
        start_run(1'b1, 6'h00, 8'd12);
        wait_done(dc);
        check("search_done_cycle", 32'(dc), 53);
        check("search_fail", 32'(fail), 0);
        check("search_found_taps", 32'(found_taps), 32'h33);
        check("search_wr_count", 32'(wr_count), 12);
        check("search_queue_left", 32'(exp_q.size()), 0);
        check_dst("search", 12);

        // Search mode, msg_len shorter than the preamble
        clear_dst(); push_exp(4);
        start_run(1'b1, 6'h00, 8'd4);
        wait_done(dc);
        check("short_done_cycle", 32'(dc), 31);
        check("short_found_taps", 32'(found_taps), 32'h33);
        check("short_wr_count", 32'(wr_count), 4);

        // Preamble byte 3 corrupted: no tap can match
        src_img[3] = src_img[3] ^ 8'h80;
        clear_dst();
        start_run(1'b1, 6'h00, 8'd12);
        wait_done(dc);
        check("corrupt_done_cycle", 32'(dc), 35);
        check("corrupt_fail", 32'(fail), 1);
        check("corrupt_wr_count", 32'(wr_count), 0);

        // msg_len = 0 in both modes
        start_run(1'b1, 6'h00, 8'd0);
        wait_done(dc);
        check("len0_search_done_cycle", 32'(dc), 1);
        check("len0_search_fail", 32'(fail), 0);
        start_run(1'b0, 6'h21, 8'd0);
        wait_done(dc);
        check("len0_fixed_done_cycle", 32'(dc), 1);
        check("len0_fixed_fail", 32'(fail), 0);
        repeat (4) @(negedge clk);
        check("len0_wr_count", 32'(wr_count), 0);

        // Reset during DECRYPT while byte 4 is being read
        set_pt_fixed(); load_src_fixed(); clear_dst(); push_exp(4);
        start_run(1'b0, 6'h21, 8'd10);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midreset_wr_count", 32'(wr_count), 4);
        check("midreset_queue_left", 32'(exp_q.size()), 0);

        // Fresh run after the reset completes normally
        clear_dst(); push_exp(10);
        start_run(1'b0, 6'h21, 8'd10);
        wait_done(dc);
        check("rerun_done_cycle", 32'(dc), 24);
        check("rerun_fail", 32'(fail), 0);
        check("rerun_wr_count", 32'(wr_count), 10);
        check_dst("rerun", 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
